// File: rtl/vga_scandoubler.sv
// vga_scandoubler: PAL 15 kHz to VGA 31 kHz line doubler with bypass; SCANDBL_SCANLINES_EN enables scanline dimming
module vga_scandoubler #(
  parameter int LINE_MAX = 1024,
  parameter int CNT_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  input  logic       enable,
  input  logic       scanlines,
  input  logic [1:0] r_in,
  input  logic [1:0] g_in,
  input  logic [1:0] b_in,
  input  logic       bright_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [1:0] r_out,
  output logic [1:0] g_out,
  output logic [1:0] b_out,
  output logic       bright_out,
  output logic       hsync_out,
  output logic       vsync_out
);
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(LINE_MAX - 1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
  logic [6:0] mem [2*LINE_MAX];
  logic [6:0] rd_q, pix_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, hslo_q, hslo_d, hs_done_q, line_len_q, hs_len_q, ocnt_q, ocnt_d;
  logic wbank_q, hs_prev_q, rep_q, rep_d, rep1_q, hslow1_q, blank1_q, vs1_q, fall, rise, wrap;
  always_comb begin
    fall = pix_ce && hs_prev_q && !hsync_in;
    rise = pix_ce && !hs_prev_q && hsync_in;
    wrap = line_len_q >= TWO && ocnt_q == line_len_q - 1'b1;
    hcnt_d = fall ? '0 : (hcnt_q == CMAX) ? hcnt_q : hcnt_q + 1'b1;
    hslo_d = rise ? '0 : (!hsync_in && hslo_q != '1) ? hslo_q + 1'b1 : hslo_q;
    ocnt_d = (fall || wrap || line_len_q < TWO) ? '0 : ocnt_q + 1'b1;
    rep_d = fall ? 1'b0 : wrap ? !rep_q : rep_q;
    pix_d = (blank1_q || hslow1_q) ? '0 : rd_q;
`ifdef SCANDBL_SCANLINES_EN
    pix_d = (scanlines && rep1_q) ? {2'b00, pix_d[5], 1'b0, pix_d[3], 1'b0, pix_d[1]} : pix_d;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wbank_q <= 1'b0;
      hs_prev_q <= 1'b1;
      hcnt_q <= '0;
      hslo_q <= '0;
      hs_done_q <= '0;
      line_len_q <= '0;
      hs_len_q <= '0;
    end else if (pix_ce) begin
      hs_prev_q <= hsync_in;
      hcnt_q <= hcnt_d;
      hslo_q <= hslo_d;
      hs_done_q <= rise ? hslo_q : hs_done_q;
      wbank_q <= wbank_q ^ fall;
      line_len_q <= fall ? hcnt_q : line_len_q;
      hs_len_q <= fall ? hs_done_q : hs_len_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && pix_ce && hcnt_q != CMAX) mem[{wbank_q, hcnt_q}] <= {bright_in, r_in, g_in, b_in};
    rd_q <= mem[{!wbank_q, ocnt_q}];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ocnt_q <= '0;
      rep_q <= 1'b0;
      rep1_q <= 1'b0;
      hslow1_q <= 1'b0;
      blank1_q <= 1'b1;
      vs1_q <= 1'b1;
    end else begin
      ocnt_q <= ocnt_d;
      rep_q <= rep_d;
      rep1_q <= rep_q;
      hslow1_q <= line_len_q >= TWO && ocnt_q < hs_len_q;
      blank1_q <= line_len_q < TWO;
      vs1_q <= (ocnt_q == '0) ? vsync_in : vs1_q;
    end
  end
  always_ff @(posedge clk)
    {vsync_out, hsync_out, bright_out, r_out, g_out, b_out} <= rst ? 9'h180 :
      enable ? {vs1_q, !hslow1_q, pix_d} : {vsync_in, hsync_in, bright_in, r_in, g_in, b_in};
`ifndef SCANDBL_SCANLINES_EN
  logic unused_scanlines;
  assign unused_scanlines = scanlines ^ rep1_q;
`endif
endmodule

// File: tb/tb_vga_scandoubler.sv
// tb_vga_scandoubler: directed self-checking bench for vga_scandoubler
module tb_vga_scandoubler;
`ifdef SCANDBL_SCANLINES_EN
  localparam bit DIM = 1'b1;
`else
  localparam bit DIM = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, pix_ce, enable, scanlines, bright_in, hsync_in, vsync_in;
  logic [1:0] r_in, g_in, b_in, r_out, g_out, b_out;
  logic bright_out, hsync_out, vsync_out;
  logic [8:0] cap [0:2299];
  logic [9:0] ocnt_a;
  logic rep_a, wbank_a, w;
  int n_chk = 0;
  int n_fail = 0;
  vga_scandoubler dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .enable(enable), .scanlines(scanlines),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .bright_in(bright_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .bright_out(bright_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  function automatic logic [6:0] pix_val(input int mode, input int x);
    logic [31:0] u;
    u = x;
    if (mode == 2) return 7'h7F;
    if (mode == 1 && x >= 1000) return 7'h2A;
    return u[6:0];
  endfunction
  task automatic feed_line(input int n, input int hs_lo, input int mode, input int vs_j);
    for (int j = 0; j <= n; j++) begin
      {bright_in, r_in, g_in, b_in} = pix_val(mode, j - 1);
      hsync_in = (j < hs_lo) ? 1'b0 : 1'b1;
      vsync_in = (vs_j >= 0 && j >= vs_j) ? 1'b0 : 1'b1;
      pix_ce = 1'b1;
      @(posedge clk);
      #1;
      if (j == 0) begin
        ocnt_a = dut.ocnt_q;
        rep_a = dut.rep_q;
        wbank_a = dut.wbank_q;
      end
      if (2 * j < 2300) cap[2*j] = {vsync_out, hsync_out, bright_out, r_out, g_out, b_out};
      pix_ce = 1'b0;
      @(posedge clk);
      #1;
      if (2 * j + 1 < 2300) cap[2*j+1] = {vsync_out, hsync_out, bright_out, r_out, g_out, b_out};
    end
  endtask
  initial begin
    int c, idx, rep;
    logic [6:0] v;
    rst = 1'b1;
    pix_ce = 1'b0;
    enable = 1'b1;
    scanlines = 1'b0;
    {bright_in, r_in, g_in, b_in} = 7'h7F;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst outs", {vsync_out, hsync_out, bright_out, r_out, g_out, b_out}, 9'h180);
    chk("rst ocnt", dut.ocnt_q, 0);
    chk("rst rep", dut.rep_q, 0);
    chk("rst wbank", dut.wbank_q, 0);
    chk("rst line_len", dut.line_len_q, 0);
    chk("rst hs_len", dut.hs_len_q, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("idle blank", {vsync_out, hsync_out, bright_out, r_out, g_out, b_out}, 9'h180);
    feed_line(384, 28, 0, -1);
    feed_line(384, 28, 0, -1);
    chk("L1 line_len", dut.line_len_q, 384);
    chk("L1 hs_len", dut.hs_len_q, 28);
    for (int e = 2; e < 770; e++) begin
      c = e - 2;
      idx = c % 384;
      v = pix_val(0, idx);
      chk($sformatf("double e%0d", e), cap[e][7:0], (idx < 28) ? 8'h00 : {1'b1, v});
    end
    feed_line(1100, 28, 1, -1);
    feed_line(1100, 28, 0, -1);
    chk("ovf line_len", dut.line_len_q, 1023);
    for (int e = 2; e < 2048; e++) begin
      c = e - 2;
      idx = c % 1023;
      v = pix_val(1, idx);
      chk($sformatf("ovf e%0d", e), cap[e][7:0], (idx < 28) ? 8'h00 : {1'b1, v});
    end
    feed_line(1, 1, 0, -1);
    feed_line(4, 1, 0, -1);
    chk("short line_len", dut.line_len_q, 1);
    for (int e = 2; e < 10; e++) chk($sformatf("short e%0d", e), cap[e][7:0], 8'h80);
    scanlines = 1'b1;
    feed_line(64, 4, 2, -1);
    feed_line(64, 4, 2, 10);
    chk("sl line_len", dut.line_len_q, 64);
    chk("sl hs_len", dut.hs_len_q, 4);
    for (int e = 2; e < 130; e++) begin
      c = e - 2;
      idx = c % 64;
      rep = c / 64;
      chk($sformatf("scan e%0d", e), cap[e][7:0], (idx < 4) ? 8'h00 : (rep == 1 && DIM) ? 8'h95 : 8'hFF);
      chk($sformatf("vsync e%0d", e), cap[e][8], (e >= 66) ? 1'b0 : 1'b1);
    end
    scanlines = 1'b0;
    feed_line(384, 28, 0, -1);
    feed_line(191, 28, 0, -1);
    chk("prewrap ocnt", dut.ocnt_q, 383);
    chk("prewrap rep", dut.rep_q, 0);
    w = dut.wbank_q;
    feed_line(384, 28, 0, -1);
    chk("wrapsync ocnt", ocnt_a, 0);
    chk("wrapsync rep", rep_a, 0);
    chk("wrapsync wbank", wbank_a, !w);
    feed_line(291, 28, 0, -1);
    chk("presync ocnt", dut.ocnt_q, 199);
    chk("presync rep", dut.rep_q, 1);
    w = dut.wbank_q;
    feed_line(4, 1, 0, -1);
    chk("resync ocnt", ocnt_a, 0);
    chk("resync rep", rep_a, 0);
    chk("resync wbank", wbank_a, !w);
    chk("resync line_len", dut.line_len_q, 291);
    enable = 1'b0;
    {bright_in, r_in, g_in, b_in} = {1'b1, 2'b10, 2'b01, 2'b11};
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    @(posedge clk);
    #1;
    chk("bypass r", r_out, 2'b10);
    chk("bypass all", {vsync_out, hsync_out, bright_out, r_out, g_out, b_out}, 9'h067);
    r_in = 2'b01;
    #2;
    chk("bypass hold", r_out, 2'b10);
    @(posedge clk);
    #1;
    chk("bypass next", r_out, 2'b01);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
